mem_arbiter: RTL and testbench

//   Shares the single RAM port between instruction fetch (read-only) and the ALU load/store path.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_watchdog.sv | 18 +
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, requester IDs and default widths for mem_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 255;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, RESP} state_t;
  typedef enum logic {REQ_IF, REQ_LS} req_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: loadable down-counter; expired is high on the TIMEOUT_CYC-th enabled cycle after load
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(TIMEOUT_CYC - 1);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = en && cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch (iIF_*) and load/store (iLS_*), one transaction at a time; oRAM_* are registered strobes, oIF_*/oLS_* return a done pulse with latched data, oERR flags a watchdog timeout when MEM_ARB_TIMEOUT_EN is defined
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iIF_CE,
  input  logic [ADDR_W-1:0]   iIF_ADDR,
  output logic                oIF_DONE,
  output logic [DATA_W-1:0]   oIF_DATA,
  input  logic                iLS_CE,
  input  logic                iLS_RD,
  input  logic                iLS_WR,
  input  logic [DATA_W/8-1:0] iLS_WSTRB,
  input  logic [ADDR_W-1:0]   iLS_ADDR,
  input  logic [DATA_W-1:0]   iLS_DATA,
  output logic                oLS_DONE,
  output logic [DATA_W-1:0]   oLS_DATA,
  output logic                oRAM_CE,
  output logic                oRAM_RD,
  output logic                oRAM_WR,
  output logic [DATA_W/8-1:0] oRAM_WSTRB,
  output logic [ADDR_W-1:0]   oRAM_ADDR,
  output logic [DATA_W-1:0]   oRAM_DATA,
  input  logic [DATA_W-1:0]   iRAM_DATA,
  input  logic                iRAM_DONE,
  output logic                oERR
);
  state_t state, state_nxt;
  req_t last;
  logic busy, start, finish, ls_go, ls_store, expired, timed_out;
  // a simultaneous RD+WR counts as a store; neither set counts as a load
  assign ls_store  = iLS_WR | (iLS_RD & iLS_WR);
  assign busy      = state == BUSY_IF || state == BUSY_LS;
  assign start     = state == IDLE && state_nxt != IDLE;
  assign finish    = busy && state_nxt == RESP;
  assign ls_go     = state_nxt == BUSY_LS;
  assign timed_out = expired && !iRAM_DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             state_nxt = iLS_CE && (!iIF_CE || last == REQ_IF) ? BUSY_LS : iIF_CE ? BUSY_IF : IDLE;
      BUSY_IF, BUSY_LS: state_nxt = iRAM_DONE || expired ? RESP : state;
      default:          state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state <= IDLE;
      last  <= REQ_IF;
    end else begin
      state <= state_nxt;
      if (start) last <= ls_go ? REQ_LS : REQ_IF;
    end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      oRAM_CE    <= 1'b0;
      oRAM_RD    <= 1'b0;
      oRAM_WR    <= 1'b0;
      oRAM_WSTRB <= '0;
      oRAM_ADDR  <= '0;
      oRAM_DATA  <= '0;
      oIF_DONE   <= 1'b0;
      oLS_DONE   <= 1'b0;
      oIF_DATA   <= '0;
      oLS_DATA   <= '0;
    end else begin
      oIF_DONE <= finish && state == BUSY_IF;
      oLS_DONE <= finish && state == BUSY_LS;
      if (start) begin
        oRAM_CE    <= 1'b1;
        oRAM_RD    <= !(ls_go && ls_store);
        oRAM_WR    <= ls_go && ls_store;
        oRAM_WSTRB <= ls_go && ls_store ? iLS_WSTRB : '0;
        oRAM_ADDR  <= ls_go ? iLS_ADDR : iIF_ADDR;
        oRAM_DATA  <= ls_go && ls_store ? iLS_DATA : '0;
      end else if (finish) begin
        oRAM_CE    <= 1'b0;
        oRAM_RD    <= 1'b0;
        oRAM_WR    <= 1'b0;
        oRAM_WSTRB <= '0;
        oRAM_ADDR  <= '0;
        oRAM_DATA  <= '0;
        if (state == BUSY_IF) oIF_DATA <= timed_out ? '0 : iRAM_DATA;
        else oLS_DATA <= timed_out ? '0 : iRAM_DATA;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk(iCLK),
    .rst(iRST),
    .load(start),
    .en(busy),
    .expired(expired)
  );
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) oERR <= 1'b0;
    else oERR <= finish && timed_out;
`else
  assign expired = 1'b0;
  assign oERR    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a grant/data model
module tb_mem_arbiter;
  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iIF_CE, iLS_CE, iLS_RD, iLS_WR, iRAM_DONE;
  logic [31:0] iIF_ADDR, iLS_ADDR, iLS_DATA, iRAM_DATA;
  logic [3:0]  iLS_WSTRB;
  logic        oIF_DONE, oLS_DONE, oRAM_CE, oRAM_RD, oRAM_WR, oERR;
  logic [31:0] oIF_DATA, oLS_DATA, oRAM_ADDR, oRAM_DATA;
  logic [3:0]  oRAM_WSTRB;
  int total = 0, bad = 0;
  bit last_ls = 0;
  logic [31:0] exp_if = '0, exp_ls = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIF_CE(iIF_CE), .iIF_ADDR(iIF_ADDR), .oIF_DONE(oIF_DONE), .oIF_DATA(oIF_DATA),
    .iLS_CE(iLS_CE), .iLS_RD(iLS_RD), .iLS_WR(iLS_WR), .iLS_WSTRB(iLS_WSTRB),
    .iLS_ADDR(iLS_ADDR), .iLS_DATA(iLS_DATA), .oLS_DONE(oLS_DONE), .oLS_DATA(oLS_DATA),
    .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR), .oRAM_WSTRB(oRAM_WSTRB),
    .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA(oRAM_DATA), .iRAM_DATA(iRAM_DATA), .iRAM_DONE(iRAM_DONE),
    .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one RAM transaction for the requester the model says wins; starts and ends at a negedge in IDLE
  task automatic serve(input bit ls, input int lat, input logic [31:0] rdata);
    int w = 0;
    logic [37:0] exp_req;
    exp_req = ls ? {!iLS_WR, iLS_WR, iLS_WR ? iLS_WSTRB : 4'h0, iLS_ADDR} : {2'b10, 4'h0, iIF_ADDR};
    do begin @(negedge iCLK); w++; end while (!oRAM_CE && w < 20);
    check("grant_latency", 64'(w), 64'd1);
    check("req", {oRAM_RD, oRAM_WR, oRAM_WSTRB, oRAM_ADDR}, exp_req);
    if (ls && iLS_WR) check("wdata", oRAM_DATA, iLS_DATA);
    for (int i = 0; i < lat; i++) begin
      @(negedge iCLK);
      check("hold", {oRAM_CE, oIF_DONE, oLS_DONE, oERR, oRAM_RD, oRAM_WR, oRAM_WSTRB, oRAM_ADDR}, {4'b1000, exp_req});
    end
    iRAM_DATA = rdata;
    iRAM_DONE = 1'b1;
    @(negedge iCLK);
    iRAM_DONE = 1'b0;
    iRAM_DATA = $urandom;
    if (ls) exp_ls = rdata;
    else exp_if = rdata;
    check("done", {oIF_DONE, oLS_DONE, oERR, oRAM_CE}, ls ? 4'b0100 : 4'b1000);
    check("if_data", oIF_DATA, exp_if);
    check("ls_data", oLS_DATA, exp_ls);
    check("ram_clear", {oRAM_RD, oRAM_WR, oRAM_WSTRB, oRAM_ADDR, oRAM_DATA}, 0);
    if (ls) iLS_CE = 1'b0;
    else iIF_CE = 1'b0;
    last_ls = ls;
    @(negedge iCLK);
    check("pulse_end", {oIF_DONE, oLS_DONE, oRAM_CE}, 0);
  endtask

  task automatic round(input bit do_if, input bit do_ls);
    bit ls_first;
    iIF_ADDR  = $urandom;
    iLS_ADDR  = $urandom;
    iLS_DATA  = $urandom;
    iLS_WSTRB = 4'($urandom);
    iLS_RD    = 1'($urandom);
    iLS_WR    = 1'($urandom);
    iIF_CE    = do_if;
    iLS_CE    = do_ls;
    ls_first  = do_ls && (!do_if || !last_ls);
    serve(ls_first, $urandom_range(0, 3), $urandom);
    if (do_if && do_ls) serve(!ls_first, $urandom_range(0, 3), $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    int w, n;
    iRST = 1'b1; iIF_CE = 0; iLS_CE = 0; iLS_RD = 0; iLS_WR = 0; iRAM_DONE = 0;
    iIF_ADDR = '0; iLS_ADDR = '0; iLS_DATA = '0; iLS_WSTRB = '0; iRAM_DATA = '0;
    repeat (2) @(negedge iCLK);
    check("rst_ctl", {oIF_DONE, oLS_DONE, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_WSTRB, oERR}, 0);
    check("rst_data", {oIF_DATA, oLS_DATA}, 0);
    check("rst_ram", {oRAM_ADDR, oRAM_DATA}, 0);
    iRST = 1'b0;
    @(negedge iCLK);
    // fetch only
    iIF_ADDR = 32'h10; iIF_CE = 1'b1;
    serve(0, 1, 32'hDEADBEEF);
    // same-cycle IF+LS three times: LS, IF, LS, ...
    repeat (3) round(1, 1);
    // store with partial byte enables
    iLS_ADDR = 32'h40; iLS_DATA = 32'h12345678; iLS_WSTRB = 4'b0011;
    iLS_WR = 1'b1; iLS_RD = 1'b0; iLS_CE = 1'b1;
    serve(1, 2, $urandom);
    // spurious RAM done while idle
    repeat (2) begin
      iRAM_DONE = 1'b1;
      @(negedge iCLK);
      iRAM_DONE = 1'b0;
      check("spurious", {oIF_DONE, oLS_DONE, oRAM_CE, oERR}, 0);
    end
    round(1, 0);
    // reset during a load
    iLS_ADDR = $urandom; iLS_RD = 1'b1; iLS_WR = 1'b0; iLS_CE = 1'b1;
    @(negedge iCLK);
    check("rst_pre_ce", {oRAM_CE, oRAM_RD}, 2'b11);
    #2 iRST = 1'b1;
    #1 check("rst_abort", {oIF_DONE, oLS_DONE, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_WSTRB, oERR, oRAM_ADDR, oIF_DATA}, 0);
    @(negedge iCLK);
    iLS_CE = 1'b0;
    check("rst_no_done", {oIF_DONE, oLS_DONE, oLS_DATA}, 0);
    iRST = 1'b0;
    last_ls = 0; exp_if = '0; exp_ls = '0;
    iIF_ADDR = $urandom; iIF_CE = 1'b1;
    serve(0, 0, $urandom);
    // reset restores last-grant = fetch, so a tie goes to LS first
    round(1, 1);
    // randomized traffic
    repeat (40) begin
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin
        iRAM_DONE = 1'b1;
        @(negedge iCLK);
        iRAM_DONE = 1'b0;
        check("spurious_rand", {oIF_DONE, oLS_DONE, oRAM_CE, oERR}, 0);
      end
      round(n[0], n[1]);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    // RAM never answers: four BUSY cycles then error with zeroed data
    iLS_ADDR = $urandom; iLS_RD = 1'b1; iLS_WR = 1'b0; iLS_CE = 1'b1;
    w = 0;
    do begin @(negedge iCLK); w++; end while (!oRAM_CE && w < 20);
    n = 0;
    while (oRAM_CE && n < 20) begin n++; @(negedge iCLK); end
    check("to_busy_cycles", 64'(n), 64'd4);
    check("to_resp", {oERR, oLS_DONE, oIF_DONE}, 3'b110);
    exp_ls = '0;
    check("to_data", oLS_DATA, exp_ls);
    iLS_CE = 1'b0;
    last_ls = 1;
    @(negedge iCLK);
    check("to_pulse_end", {oERR, oLS_DONE}, 0);
    // RAM done on the expiry cycle wins
    iIF_ADDR = $urandom; iIF_CE = 1'b1;
    serve(0, 3, $urandom);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
